ps2_keys: RTL and testbench

- PS/2 keyboard receiver and decoder that produces the 5-bit `keys` held-key vector consumed by the VGA debug page, plus raw scan-code reporting.
- Runs in the `vga_clk` domain, so its outputs feed the pixel pipeline with no crossing logic.
- Synchronises and filters the PS/2 lines, deframes 11-bit frames, tracks E0/F0 prefixes, and maintains a make/break state per mapped key.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_keys_if.sv | 21 ++
 rtl/ps2_rx_frame.sv | 155 +++++++++++++++
 rtl/ps2_keys.sv | 107 ++++++++++
 tb/tb_ps2_keys.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and helpers for the PS/2 key decoder.
package ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Prefix codes
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  // Plain (non-extended) key codes
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  // Extended (E0-prefixed) arrow codes
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions inside the held-key vector
  localparam int KEY_UP    = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_SPACE = 4;

  // Inter-edge timeout expressed in clock cycles
  function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
    return (clk_hz / 1_000_000) * timeout_us;
  endfunction

  // True when data plus parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keys_if.sv
// PS/2 pin inputs and decoded key/scan-code outputs of the ps2_keys block.
interface ps2_keys_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] keys;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  // Side that drives the pins and consumes the decoded results
  modport master (
    output ps2_clk, ps2_data,
    input  keys, scan_code, scan_valid, frame_err
  );

  // The decoder itself
  modport slave (
    input  ps2_clk, ps2_data,
    output keys, scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and 11-bit frame receiver: synchronises and
// deglitches the pins, deframes start/data/parity/stop and flags errors.
// byte_valid/err are single-cycle strobes built from registered state.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic       vga_clk,
  input  logic       vga_rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int TIMEOUT_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int FLT_W       = $clog2(FILTER_LEN + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  logic [1:0]       clk_sync_r;
  logic [1:0]       data_sync_r;
  logic             filt_r;
  logic [FLT_W-1:0] flt_cnt_r;
  logic             fall_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  ps2_state_e state_r, state_nxt;
  logic [2:0] bit_cnt_r, bit_cnt_nxt;
  logic [7:0] shift_r, shift_nxt;
  logic       par_r, par_nxt;

  logic data_bit_s;
  logic timeout_s;

  assign data_bit_s = data_sync_r[1];
  assign timeout_s  = (state_r != ST_IDLE) && !fall_r && (tmo_cnt_r == TMO_LAST);
  assign rx_byte    = shift_r;

  // Two-flop synchronisers for the asynchronous PS/2 pins (idle high)
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Clock deglitch: flip only after FILTER_LEN disagreeing samples; strobe falls
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      filt_r    <= 1'b1;
      flt_cnt_r <= {FLT_W{1'b0}};
      fall_r    <= 1'b0;
    end else begin
      fall_r <= 1'b0;
      if (clk_sync_r[1] == filt_r) begin
        flt_cnt_r <= {FLT_W{1'b0}};
      end else if (flt_cnt_r == FLT_LAST) begin
        filt_r    <= ~filt_r;
        flt_cnt_r <= {FLT_W{1'b0}};
        fall_r    <= filt_r;
      end else begin
        flt_cnt_r <= flt_cnt_r + FLT_W'(1);
      end
    end
  end

  // Inter-edge watchdog: restarts on every fall, idle while no frame is open
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r == ST_IDLE) || fall_r) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (tmo_cnt_r != TMO_LAST) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Frame FSM state register
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      shift_r   <= shift_nxt;
      par_r     <= par_nxt;
    end
  end

  // Frame FSM next-state and strobe logic; timeout wins unless a fall arrives
  always_comb begin
    state_nxt   = state_r;
    bit_cnt_nxt = bit_cnt_r;
    shift_nxt   = shift_r;
    par_nxt     = par_r;
    byte_valid  = 1'b0;
    err         = 1'b0;
    if (timeout_s) begin
      state_nxt = ST_IDLE;
      err       = 1'b1;
    end else if (fall_r) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_bit_s) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = 3'd0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_nxt   = {data_bit_s, shift_r[7:1]};
          bit_cnt_nxt = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_nxt = ST_PARITY;
          end else begin
            state_nxt = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_nxt   = data_bit_s;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (data_bit_s && odd_parity_ok(shift_r, par_r)) begin
            byte_valid = 1'b1;
          end else begin
            err = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

endmodule

// File: rtl/ps2_keys.sv
// PS/2 keyboard decoder for the VGA debug page: tracks E0/F0 prefixes,
// maps scan codes onto the 5-bit held-key vector and reports raw bytes.
module ps2_keys
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic       vga_clk,
  input  logic       vga_rst,
  ps2_keys_if.slave  bus
);

  logic [7:0] rx_byte_s;
  logic       byte_valid_s;
  logic       err_s;
  logic [4:0] key_mask_s;

  logic       ext_r;
  logic       brk_r;
  logic [4:0] keys_r;
  logic [7:0] scan_code_r;
  logic       scan_valid_r;
  logic       frame_err_r;

  ps2_rx_frame #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) u_rx (
    .vga_clk    (vga_clk),
    .vga_rst    (vga_rst),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s),
    .err        (err_s)
  );

  // Key map lookup; the ext flag selects between the two tables
  always_comb begin
    key_mask_s = 5'b00000;
    if (ext_r) begin
      case (rx_byte_s)
        SC_UP:    key_mask_s[KEY_UP]    = 1'b1;
        SC_LEFT:  key_mask_s[KEY_LEFT]  = 1'b1;
        SC_DOWN:  key_mask_s[KEY_DOWN]  = 1'b1;
        SC_RIGHT: key_mask_s[KEY_RIGHT] = 1'b1;
        default:  key_mask_s = 5'b00000;
      endcase
    end else begin
      case (rx_byte_s)
        SC_W:     key_mask_s[KEY_UP]    = 1'b1;
        SC_A:     key_mask_s[KEY_LEFT]  = 1'b1;
        SC_S:     key_mask_s[KEY_DOWN]  = 1'b1;
        SC_D:     key_mask_s[KEY_RIGHT] = 1'b1;
        SC_SPACE: key_mask_s[KEY_SPACE] = 1'b1;
        default:  key_mask_s = 5'b00000;
      endcase
    end
  end

  // Output registers, prefix flags and make/break key state
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      ext_r        <= 1'b0;
      brk_r        <= 1'b0;
      keys_r       <= 5'b00000;
      scan_code_r  <= 8'h00;
      scan_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      scan_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (err_s) begin
        frame_err_r <= 1'b1;
        ext_r       <= 1'b0;
        brk_r       <= 1'b0;
      end else if (byte_valid_s) begin
        scan_code_r  <= rx_byte_s;
        scan_valid_r <= 1'b1;
        if (rx_byte_s == SC_E0) begin
          ext_r <= 1'b1;
        end else if (rx_byte_s == SC_F0) begin
          brk_r <= 1'b1;
        end else begin
          if (brk_r) begin
            keys_r <= keys_r & ~key_mask_s;
          end else begin
            keys_r <= keys_r | key_mask_s;
          end
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      end else begin
        ext_r <= ext_r;
      end
    end
  end

  assign bus.keys       = keys_r;
  assign bus.scan_code  = scan_code_r;
  assign bus.scan_valid = scan_valid_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_keys.sv
// Self-checking bench for ps2_keys: drives PS/2 frames on the pins, keeps an
// independent key model and checks every scan_valid/frame_err event in order.
module tb_ps2_keys;

  localparam int CLK_HZ     = 1_000_000;
  localparam int TIMEOUT_US = 200;
  localparam int FILTER_LEN = 8;
  localparam int TMO        = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int HALF       = 20;

  logic vga_clk;
  logic vga_rst;
  ps2_keys_if bus ();

  ps2_keys #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .bus     (bus)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic [4:0] keys;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   t_fall   = 0;
  int   t_err    = 0;
  int   lat_ref  = 0;
  logic prev_sv  = 1'b0;
  logic prev_fe  = 1'b0;

  logic [4:0] m_keys = 5'b00000;
  logic       m_ext  = 1'b0;
  logic       m_brk  = 1'b0;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  function automatic logic [4:0] map_code(input logic [7:0] c, input logic e);
    logic [4:0] m;
    m = 5'b00000;
    if (e) begin
      case (c)
        8'h75: m = 5'b00001;
        8'h6B: m = 5'b00010;
        8'h72: m = 5'b00100;
        8'h74: m = 5'b01000;
        default: m = 5'b00000;
      endcase
    end else begin
      case (c)
        8'h1D: m = 5'b00001;
        8'h1C: m = 5'b00010;
        8'h1B: m = 5'b00100;
        8'h23: m = 5'b01000;
        8'h29: m = 5'b10000;
        default: m = 5'b00000;
      endcase
    end
    return m;
  endfunction

  // One PS/2 bit: data set while clock high, then a full low/high clock cycle
  task automatic drive_bit(input logic v);
    bus.ps2_data = v;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b0;
    t_fall = cyc;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(frame[i]);
  endtask

  // Full frame with model update and scoreboard push
  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    exp_t e;
    logic [4:0] m;
    logic par;
    par = ~(^b) ^ bad_par;
    if (bad_par) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      e.is_err = 1'b1;
    end else begin
      e.is_err = 1'b0;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        m = map_code(b, m_ext);
        if (m_brk) m_keys = m_keys & ~m;
        else m_keys = m_keys | m;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    e.code = b;
    e.keys = m_keys;
    exp_q.push_back(e);
    send_bits({1'b1, par, b, 1'b0}, 11);
    wait_cyc(2 * HALF);
  endtask

  task automatic settle_and_check(input string tag);
    wait_cyc(40);
    check_eq({tag, "_q_empty"}, exp_q.size(), 0);
    check_eq({tag, "_keys"}, bus.keys, m_keys);
  endtask

  // Scoreboard monitor, sampling on the falling clock edge
  always @(negedge vga_clk) begin
    exp_t e;
    if (!vga_rst) begin
      if (prev_sv) check_eq("scan_valid_pulse", bus.scan_valid, 0);
      if (prev_fe) check_eq("frame_err_pulse", bus.frame_err, 0);
      if (bus.scan_valid || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", {bus.scan_valid, bus.frame_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check_eq("event_kind", {bus.scan_valid, bus.frame_err}, e.is_err ? 2'b01 : 2'b10);
          if (!e.is_err) check_eq("scan_code", bus.scan_code, e.code);
          check_eq("event_keys", bus.keys, e.keys);
        end
        if (bus.scan_valid) begin
          lat_ref = cyc - t_fall;
          check_eq("latency_in_range", (lat_ref >= 10 && lat_ref <= 12), 1);
        end
        if (bus.frame_err) t_err = cyc;
      end
    end
    prev_sv <= bus.scan_valid;
    prev_fe <= bus.frame_err;
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    vga_rst      = 1'b1;
    wait_cyc(3);
    check_eq("rst_keys", bus.keys, 5'b00000);
    check_eq("rst_scan_code", bus.scan_code, 8'h00);
    check_eq("rst_scan_valid", bus.scan_valid, 1'b0);
    check_eq("rst_frame_err", bus.frame_err, 1'b0);
    vga_rst = 1'b0;
    wait_cyc(5);

    // make and break of W
    send_byte(8'h1D, 1'b0);
    settle_and_check("w_make");
    check_eq("w_make_exact", bus.keys, 5'b00001);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    settle_and_check("w_break");
    check_eq("w_break_exact", bus.keys, 5'b00000);

    // two keys held, release one
    send_byte(8'h1D, 1'b0);
    send_byte(8'h23, 1'b0);
    settle_and_check("wd_make");
    check_eq("wd_make_exact", bus.keys, 5'b01001);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    settle_and_check("w_release");
    check_eq("w_release_exact", bus.keys, 5'b01000);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    settle_and_check("d_release");

    // extended arrows; bare 75 has no effect
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    settle_and_check("up_make");
    check_eq("up_make_exact", bus.keys, 5'b00001);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    settle_and_check("up_break");
    check_eq("up_break_exact", bus.keys, 5'b00000);
    send_byte(8'h23, 1'b0);
    send_byte(8'h75, 1'b0);
    settle_and_check("bare_75");
    check_eq("bare_75_exact", bus.keys, 5'b01000);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFA, 1'b0);
    settle_and_check("unmapped");
    check_eq("unmapped_code", bus.scan_code, 8'hFA);

    // parity error then a good A
    send_byte(8'h1C, 1'b1);
    settle_and_check("par_err");
    send_byte(8'h1C, 1'b0);
    settle_and_check("a_make");
    check_eq("a_make_exact", bus.keys, 5'b00010);

    // timeout: start plus four data bits, then clock idles high
    begin
      exp_t e;
      m_ext = 1'b0;
      m_brk = 1'b0;
      e.is_err = 1'b1;
      e.code   = 8'h00;
      e.keys   = m_keys;
      exp_q.push_back(e);
    end
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    wait_cyc(TMO + 40);
    check_eq("tmo_q_empty", exp_q.size(), 0);
    check_eq("tmo_delay", t_err - t_fall - lat_ref, TMO);
    send_byte(8'h29, 1'b0);
    settle_and_check("space_make");
    check_eq("space_make_exact", bus.keys, 5'b10010);

    // 3-cycle glitch on ps2_clk is ignored
    bus.ps2_clk = 1'b0;
    wait_cyc(3);
    bus.ps2_clk = 1'b1;
    settle_and_check("glitch");

    // reset in the middle of a frame
    send_bits({1'b1, 1'b0, 8'h1B, 1'b0}, 4);
    vga_rst = 1'b1;
    wait_cyc(3);
    check_eq("midrst_keys", bus.keys, 5'b00000);
    check_eq("midrst_scan_code", bus.scan_code, 8'h00);
    check_eq("midrst_scan_valid", bus.scan_valid, 1'b0);
    check_eq("midrst_frame_err", bus.frame_err, 1'b0);
    m_keys = 5'b00000;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    exp_q.delete();
    vga_rst = 1'b0;
    wait_cyc(5);
    send_byte(8'h29, 1'b0);
    settle_and_check("post_rst");
    check_eq("post_rst_exact", bus.keys, 5'b10000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
